// File: rtl/spi_slave_if.sv
// spi_slave_if: parallel tx-load / rx-valid bus between spi_slave and local logic.
interface spi_slave_if #(parameter int DATA_W = 8);
    logic [DATA_W-1:0] tx_data;
    logic [DATA_W-1:0] rx_data;
    logic              tx_load;
    logic              tx_ack;
    logic              rx_valid;
    logic              busy;
    modport master (output tx_data, tx_load, input tx_ack, rx_data, rx_valid, busy);
    modport slave  (input tx_data, tx_load, output tx_ack, rx_data, rx_valid, busy);
endinterface

// File: rtl/spi_slave.sv
// spi_slave: oversampled SPI slave, all four CPOL/CPHA modes, full-duplex DATA_W-bit words.
// Define SPI_SLAVE_LSB_FIRST_EN to run both shifters LSB-first (default MSB-first).
module spi_slave #(parameter int DATA_W = 8) (
    input  logic       clk,
    input  logic       reset,
    input  logic       spi_clk,
    input  logic       cs,
    input  logic       mosi,
    input  logic       polarity,
    input  logic       phase,
    output logic       miso,
    spi_slave_if.slave bus
);
    localparam int CW = $clog2(DATA_W + 1);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t            state;
    logic [CW-1:0]     cnt;
    logic [1:0]        sclk_s, cs_s, mosi_s;
    logic              sclk_d, cs_d, pol, pha;
    logic [DATA_W-1:0] tx_buf, tx_sh, rx_sh;
    logic [DATA_W-1:0] tx_adv, buf_adv, rx_next;
    logic              tx_head, buf_head, sclk_edge, lead, trail, sample, shift_e;
`ifdef SPI_SLAVE_LSB_FIRST_EN
    assign tx_head  = tx_sh[0];
    assign buf_head = tx_buf[0];
    assign tx_adv   = tx_sh >> 1;
    assign buf_adv  = tx_buf >> 1;
    assign rx_next  = {mosi_s[1], rx_sh[DATA_W-1:1]};
`else
    assign tx_head  = tx_sh[DATA_W-1];
    assign buf_head = tx_buf[DATA_W-1];
    assign tx_adv   = tx_sh << 1;
    assign buf_adv  = tx_buf << 1;
    assign rx_next  = {rx_sh[DATA_W-2:0], mosi_s[1]};
`endif
    assign sclk_edge = sclk_s[1] ^ sclk_d;
    assign lead      = sclk_edge && (sclk_d == pol);
    assign trail     = sclk_edge && (sclk_s[1] == pol);
    assign sample    = pha ? trail : lead;
    assign shift_e   = pha ? lead : trail;
    assign bus.busy  = (state != IDLE);
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            cnt          <= '0;
            sclk_s       <= 2'b00;
            cs_s         <= 2'b11;
            mosi_s       <= 2'b00;
            sclk_d       <= 1'b0;
            cs_d         <= 1'b1;
            pol          <= 1'b0;
            pha          <= 1'b0;
            tx_buf       <= '0;
            tx_sh        <= '0;
            rx_sh        <= '0;
            miso         <= 1'b0;
            bus.tx_ack   <= 1'b0;
            bus.rx_valid <= 1'b0;
            bus.rx_data  <= '0;
        end else begin
            sclk_s       <= {sclk_s[0], spi_clk};
            cs_s         <= {cs_s[0], cs};
            mosi_s       <= {mosi_s[0], mosi};
            sclk_d       <= sclk_s[1];
            cs_d         <= cs_s[1];
            bus.tx_ack   <= 1'b0;
            bus.rx_valid <= 1'b0;
            if (bus.tx_load) tx_buf <= bus.tx_data;
            case (state)
                IDLE: begin
                    miso <= 1'b0;
                    if (cs_d && !cs_s[1]) begin
                        pol        <= polarity;
                        pha        <= phase;
                        cnt        <= '0;
                        bus.tx_ack <= 1'b1;
                        state      <= SHIFT;
                        // CPHA=0 has no leading shift edge, so the first bit goes out now
                        tx_sh      <= phase ? tx_buf : buf_adv;
                        miso       <= phase ? 1'b0 : buf_head;
                    end
                end
                SHIFT: begin
                    if (cs_s[1]) begin
                        state <= IDLE;
                        miso  <= 1'b0;
                    end else begin
                        if (sample) begin
                            rx_sh <= rx_next;
                            cnt   <= cnt + CW'(1);
                            if (cnt == CW'(DATA_W - 1)) state <= DONE;
                        end
                        if (shift_e) begin
                            miso  <= tx_head;
                            tx_sh <= tx_adv;
                        end
                    end
                end
                DONE: begin
                    bus.rx_data  <= rx_sh;
                    bus.rx_valid <= 1'b1;
                    if (cs_s[1]) begin
                        state <= IDLE;
                        miso  <= 1'b0;
                    end else begin
                        tx_sh      <= tx_buf;
                        bus.tx_ack <= 1'b1;
                        cnt        <= '0;
                        state      <= SHIFT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: randomized SPI master driving spi_slave, rx words checked by a queue-based monitor.
module tb_spi_slave;
    localparam int W = 8;
    localparam int H = 8;
    logic clk = 0, reset = 0, spi_clk = 0, cs = 1, mosi = 0, miso, polarity = 0, phase = 0;
    spi_slave_if #(.DATA_W(W)) bus();
    spi_slave #(.DATA_W(W)) dut (
        .clk(clk), .reset(reset), .spi_clk(spi_clk), .cs(cs), .mosi(mosi),
        .polarity(polarity), .phase(phase), .miso(miso), .bus(bus.slave)
    );
    always #5 clk = ~clk;
    int errors = 0, checks = 0;
    logic [W-1:0] rxq[$];
    logic [W-1:0] last_rx = '0, exp_rx;
    logic [W-1:0] mw[2], got[2];
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    // wire position of the b-th transmitted bit
    function automatic int pos(input int b);
`ifdef SPI_SLAVE_LSB_FIRST_EN
        return b;
`else
        return W - 1 - b;
`endif
    endfunction
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic load(input logic [W-1:0] v);
        bus.tx_data = v;
        bus.tx_load = 1;
        cyc(1);
        bus.tx_load = 0;
    endtask
    task automatic xfer(input logic pol, input logic pha, input int nb, input bit end_cs);
        polarity = pol;
        phase    = pha;
        spi_clk  = pol;
        cyc(H);
        cs = 0;
        for (int k = 0; k < nb; k++) begin
            if (k == 1) begin
                polarity = ~pol;
                phase    = ~pha;
            end
            if (!pha) begin
                mosi = mw[k / W][pos(k % W)];
                cyc(H);
                got[k / W][pos(k % W)] = miso;
                spi_clk = ~pol;
                cyc(H);
                spi_clk = pol;
            end else begin
                cyc(H);
                spi_clk = ~pol;
                mosi = mw[k / W][pos(k % W)];
                cyc(H);
                got[k / W][pos(k % W)] = miso;
                spi_clk = pol;
            end
        end
        cyc(H);
        if (end_cs) cs = 1;
        cyc(H);
    endtask
    task automatic run(input logic pol, input logic pha, input logic [W-1:0] tx, input logic [W-1:0] rx);
        load(tx);
        mw[0] = rx;
        rxq.push_back(rx);
        xfer(pol, pha, W, 1);
        check("miso_word", got[0], tx);
    endtask
    always @(negedge clk) begin
        if (bus.rx_valid === 1'b1) begin
            if (rxq.size() == 0) check("unexpected_rx_valid", 1, 0);
            else begin
                exp_rx = rxq.pop_front();
                check("rx_data", bus.rx_data, exp_rx);
                last_rx = exp_rx;
            end
        end
    end
    initial begin
        int n;
        bus.tx_data = '0;
        bus.tx_load = 0;
        cyc(3);
        check("rst_miso", miso, 0);
        check("rst_tx_ack", bus.tx_ack, 0);
        check("rst_rx_valid", bus.rx_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_rx_data", bus.rx_data, 0);
        reset = 1;
        cyc(4);
        for (int m = 0; m < 4; m++) run(m[1], m[0], 8'hCA, 8'hAF);
        run(0, 0, 8'h01, 8'h80);
        // back-to-back words, tx buffer refreshed after the first copy
        for (int m = 0; m < 4; m += 3) begin
            load(8'h3C);
            mw[0] = W'($urandom);
            mw[1] = W'($urandom);
            rxq.push_back(mw[0]);
            rxq.push_back(mw[1]);
            fork
                xfer(m[1], m[0], 2 * W, 1);
                begin
                    n = 0;
                    while (bus.tx_ack !== 1'b1 && n < 200) begin
                        cyc(1);
                        n++;
                    end
                    if (n >= 200) check("tx_ack_timeout", 0, 1);
                    else begin
                        cyc(1);
                        load(8'h81);
                    end
                end
            join
            check("b2b_word0", got[0], 8'h3C);
            check("b2b_word1", got[1], 8'h81);
        end
        for (int i = 0; i < 12; i++)
            run(logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)), W'($urandom), W'($urandom));
        // abort after 5 bits
        load(8'h55);
        mw[0] = W'($urandom);
        xfer(0, 0, 5, 0);
        cs = 1;
        cyc(4);
        check("abort_busy", bus.busy, 0);
        check("abort_miso", miso, 0);
        check("abort_rx_data", bus.rx_data, last_rx);
        cyc(H);
        // reset in the middle of a frame
        load(8'hA5);
        mw[0] = W'($urandom);
        xfer(1, 1, 3, 0);
        reset = 0;
        cyc(2);
        check("midrst_miso", miso, 0);
        check("midrst_busy", bus.busy, 0);
        check("midrst_rx_data", bus.rx_data, 0);
        check("midrst_tx_ack", bus.tx_ack, 0);
        check("midrst_rx_valid", bus.rx_valid, 0);
        cs = 1;
        cyc(4);
        reset = 1;
        last_rx = '0;
        cyc(4);
        run(0, 0, 8'h96, 8'h3B);
        n = 0;
        while (rxq.size() != 0 && n < 100) begin
            cyc(1);
            n++;
        end
        check("rxq_drained", rxq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
